// File: rtl/btn_stb_pkg.sv
// Shared types and helpers for the push-button strobe generator.
//   state_t   : debounce/repeat FSM states
//   cnt_width : width of the shared down-counter, wide enough for the
//               largest of the debounce, hold and repeat intervals
package btn_stb_pkg;

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        REPEATING,
        RELEASE_WAIT
    } state_t;

    function automatic int cnt_width(input int count, input int hold, input int rpt);
        int m;
        m = count;
        if (hold > m) m = hold;
        if (rpt > m)  m = rpt;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_stb_if.sv
// Button-side bundle: raw button level in, debounced level and strobes out.
//   btn         : raw asynchronous button level
//   pressed     : debounced level
//   stb_press   : one-cycle pulse on debounced press
//   stb_repeat  : one-cycle pulse per auto-repeat tick
//   stb_release : one-cycle pulse on debounced release
// master = the side that owns the button (board / bench), slave = btn_stb.
interface btn_stb_if;
    import btn_stb_pkg::*;

    logic btn;
    logic pressed;
    logic stb_press;
    logic stb_repeat;
    logic stb_release;

    modport master (
        output btn,
        input  pressed,
        input  stb_press,
        input  stb_repeat,
        input  stb_release
    );

    modport slave (
        input  btn,
        output pressed,
        output stb_press,
        output stb_repeat,
        output stb_release
    );

endinterface

// File: rtl/btn_stb_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_stb.sv
// Push-button conditioner: synchronizes a raw button level, debounces it and
// emits single-cycle press / auto-repeat / release strobes.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : btn in; pressed, stb_press, stb_repeat, stb_release out
// Parameters:
//   COUNT      debounce window (cycles the synchronized level must be stable), >=1
//   HOLD       cycles from stb_press to the first stb_repeat, 0 disables repeat
//   REPEAT     cycles between successive stb_repeat pulses, >=1
//   ACTIVE_LOW 1 when the button reads low while pressed
module btn_stb
    import btn_stb_pkg::*;
#(
    parameter int COUNT      = 120000,
    parameter int HOLD       = 12000000,
    parameter int REPEAT     = 3000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    btn_stb_if.slave  bus
);

    localparam int CW = cnt_width(COUNT, HOLD, REPEAT);
    localparam bit REPEAT_EN = (HOLD != 0);

    // Reload values are N-1 because the counter reaches 0 on the Nth edge.
    // With repeat disabled the hold reload is irrelevant (cnt holds), so 0.
    localparam logic [CW-1:0] COUNT_LD  = CW'(COUNT - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(REPEAT_EN ? HOLD - 1 : 0);
    localparam logic [CW-1:0] REPEAT_LD = CW'(REPEAT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic btn_raw;
    logic btn_s;

    assign btn_raw = bus.btn ^ ACTIVE_LOW;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    state_t        state_q,       state_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic          pressed_q,     pressed_d;
    logic          stb_press_q,   stb_press_d;
    logic          stb_repeat_q,  stb_repeat_d;
    logic          stb_release_q, stb_release_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pressed_d     = pressed_q;
        stb_press_d   = 1'b0;
        stb_repeat_d  = 1'b0;
        stb_release_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = COUNT_LD;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    // bounce before the window closed: silently give up
                    state_d = RELEASED;
                end else if (cnt_q == '0) begin
                    state_d     = PRESSED;
                    pressed_d   = 1'b1;
                    stb_press_d = 1'b1;
                    cnt_d       = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = COUNT_LD;
                end else if (REPEAT_EN) begin
                    if (cnt_q == '0) begin
                        state_d      = REPEATING;
                        stb_repeat_d = 1'b1;
                        cnt_d        = REPEAT_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            REPEATING: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = COUNT_LD;
                end else if (cnt_q == '0) begin
                    stb_repeat_d = 1'b1;
                    cnt_d        = REPEAT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    // release bounce: still held, hold timer starts over
                    state_d = PRESSED;
                    cnt_d   = HOLD_LD;
                end else if (cnt_q == '0) begin
                    state_d       = RELEASED;
                    pressed_d     = 1'b0;
                    stb_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d   = RELEASED;
                pressed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            pressed_q     <= 1'b0;
            stb_press_q   <= 1'b0;
            stb_repeat_q  <= 1'b0;
            stb_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pressed_q     <= pressed_d;
            stb_press_q   <= stb_press_d;
            stb_repeat_q  <= stb_repeat_d;
            stb_release_q <= stb_release_d;
        end
    end

    assign bus.pressed     = pressed_q;
    assign bus.stb_press   = stb_press_q;
    assign bus.stb_repeat  = stb_repeat_q;
    assign bus.stb_release = stb_release_q;

endmodule

// File: tb/tb_btn_stb.sv
// Directed bench for btn_stb. dut_a: COUNT=4 HOLD=20 REPEAT=8 active-high.
// dut_b: COUNT=4 HOLD=0 REPEAT=8 active-low. Edge k is the k-th posedge after
// btn changes; outputs are sampled 1 time unit after each edge.
module tb_btn_stb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    btn_stb_if if_a ();
    btn_stb_if if_b ();

    btn_stb #(.COUNT(4), .HOLD(20), .REPEAT(8), .ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    btn_stb #(.COUNT(4), .HOLD(0), .REPEAT(8), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  rst;
        logic  btn;
        int    cycles;
        int    n_press;
        int    n_repeat;
        int    n_release;
        logic  pressed_end;
    } seg_t;

    seg_t segs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int strobes_a();
        return int'(if_a.stb_press) + int'(if_a.stb_repeat) + int'(if_a.stb_release);
    endfunction

    function automatic int strobes_b();
        return int'(if_b.stb_press) + int'(if_b.stb_repeat) + int'(if_b.stb_release);
    endfunction

    initial begin
        // ---------------- reset state ----------------
        rst       = 1'b1;
        if_a.btn  = 1'b0;
        if_b.btn  = 1'b1;   // active-low released
        repeat (3) tick();
        check("rst a.pressed",     if_a.pressed,     0);
        check("rst a.stb_press",   if_a.stb_press,   0);
        check("rst a.stb_repeat",  if_a.stb_repeat,  0);
        check("rst a.stb_release", if_a.stb_release, 0);
        check("rst b.pressed",     if_b.pressed,     0);
        check("rst b.stb_press",   if_b.stb_press,   0);
        check("rst b.stb_repeat",  if_b.stb_repeat,  0);
        check("rst b.stb_release", if_b.stb_release, 0);
        rst = 1'b0;
        repeat (4) tick();
        $display("reset done: a.pressed=%0b b.pressed=%0b", if_a.pressed, if_b.pressed);

        // ---------------- hold 60 cycles then release (exact timing) ----------------
        // press at 6, repeats 26,34,42,50,58, release first low at 60 -> strobe at 66
        for (int k = 0; k < 72; k++) begin
            if_a.btn = (k < 60);
            tick();
            check($sformatf("hold a.stb_press k=%0d", k), if_a.stb_press, (k == 6));
            check($sformatf("hold a.stb_repeat k=%0d", k), if_a.stb_repeat,
                  (k >= 26 && k <= 58 && ((k - 26) % 8) == 0));
            check($sformatf("hold a.stb_release k=%0d", k), if_a.stb_release, (k == 66));
            check($sformatf("hold a.pressed k=%0d", k), if_a.pressed, (k >= 6 && k < 66));
            check($sformatf("hold a.mutex k=%0d", k), (strobes_a() <= 1), 1);
        end
        $display("hold/release sequence done");

        // ---------------- table-driven segments ----------------
        segs.push_back('{"idle",         1'b0, 1'b0,  5, 0, 0, 0, 1'b0});
        segs.push_back('{"bounce_hi",    1'b0, 1'b1,  3, 0, 0, 0, 1'b0});
        segs.push_back('{"bounce_lo",    1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
        segs.push_back('{"press",        1'b0, 1'b1,  7, 1, 0, 0, 1'b1});
        segs.push_back('{"rel_glitch",   1'b0, 1'b0,  2, 0, 0, 0, 1'b1});
        segs.push_back('{"hold_restart", 1'b0, 1'b1, 22, 0, 0, 0, 1'b1});
        segs.push_back('{"first_rep",    1'b0, 1'b1,  1, 0, 1, 0, 1'b1});
        segs.push_back('{"pre_rst",      1'b0, 1'b1,  3, 0, 0, 0, 1'b1});
        segs.push_back('{"rst_mid",      1'b1, 1'b1,  1, 0, 0, 0, 1'b0});
        segs.push_back('{"repress_wait", 1'b0, 1'b1,  6, 0, 0, 0, 1'b0});
        segs.push_back('{"repress",      1'b0, 1'b1,  1, 1, 0, 0, 1'b1});
        segs.push_back('{"release_wait", 1'b0, 1'b0,  6, 0, 0, 0, 1'b1});
        segs.push_back('{"release",      1'b0, 1'b0,  1, 0, 0, 1, 1'b0});
        segs.push_back('{"idle_end",     1'b0, 1'b0,  5, 0, 0, 0, 1'b0});

        foreach (segs[i]) begin
            int np, nr, nl;
            np = 0; nr = 0; nl = 0;
            rst      = segs[i].rst;
            if_a.btn = segs[i].btn;
            for (int c = 0; c < segs[i].cycles; c++) begin
                tick();
                np += int'(if_a.stb_press);
                nr += int'(if_a.stb_repeat);
                nl += int'(if_a.stb_release);
                check($sformatf("%s mutex c=%0d", segs[i].name, c), (strobes_a() <= 1), 1);
            end
            rst = 1'b0;
            check({segs[i].name, " n_press"},   np, segs[i].n_press);
            check({segs[i].name, " n_repeat"},  nr, segs[i].n_repeat);
            check({segs[i].name, " n_release"}, nl, segs[i].n_release);
            check({segs[i].name, " pressed"},   if_a.pressed, segs[i].pressed_end);
            $display("seg %-13s rst=%0b btn=%0b cyc=%0d press=%0d repeat=%0d release=%0d pressed=%0b",
                     segs[i].name, segs[i].rst, segs[i].btn, segs[i].cycles, np, nr, nl, if_a.pressed);
        end

        // ---------------- active-low, repeat disabled ----------------
        // btn low (pressed) for 50 edges: press at 6, never a repeat; then release at 56
        for (int k = 0; k < 62; k++) begin
            if_b.btn = (k >= 50);
            tick();
            check($sformatf("al b.stb_press k=%0d", k), if_b.stb_press, (k == 6));
            check($sformatf("al b.stb_repeat k=%0d", k), if_b.stb_repeat, 0);
            check($sformatf("al b.stb_release k=%0d", k), if_b.stb_release, (k == 56));
            check($sformatf("al b.pressed k=%0d", k), if_b.pressed, (k >= 6 && k < 56));
            check($sformatf("al b.mutex k=%0d", k), (strobes_b() <= 1), 1);
        end
        $display("active-low hold sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
